// File: rtl/div16.sv
// div16: sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next division completes.
module div16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] rem_q, dvd_q, dvs_q, quo_q, rout_q;
  logic        busy_q, done_q, dz_q;
  logic [16:0] trial;
  logic [15:0] diff, rem_d, dvd_d;
  logic        ge;
  // A kept remainder is always below the divisor, so 16 stored bits suffice;
  // the shifted trial value needs 17 and the wrapped 16-bit difference is exact when ge.
  always_comb begin
    trial = {rem_q, dvd_q[15]};
    diff  = trial[15:0] + ~dvs_q + 16'd1;
    ge    = trial >= {1'b0, dvs_q};
    rem_d = ge ? diff : trial[15:0];
    dvd_d = {dvd_q[14:0], ge};
  end
  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= start ? RUN : IDLE;
          busy_q  <= start;
          done_q  <= 1'b0;
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= dvd_d;
            rout_q  <= rem_d;
            dz_q    <= dvs_q == 16'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rout_q;
  assign div_zero  = dz_q;
endmodule
